// File: rtl/icache_fetch.sv
// Direct-mapped, read-only instruction cache in front of the fetch queue.
// Returns whole 128-bit lines; misses refill in four in-order 32-bit beats.
module icache_fetch #(
  parameter int INDEX_BITS = 6
) (
  input  logic         clock,
  input  logic         nreset,
  input  logic         rd_en,
  input  logic [31:0]  addr,
  output logic [127:0] dout,
  output logic         dout_valid,
  output logic         mem_rd_en,
  output logic [31:0]  mem_addr,
  input  logic [31:0]  mem_data,
  input  logic         mem_data_valid
);
  localparam int TAG_BITS = 28 - INDEX_BITS;
  localparam int LINES    = 1 << INDEX_BITS;

  typedef enum logic [1:0] {IDLE, LOOKUP, REFILL, RESP} state_t;
  state_t state, state_nxt;

  logic [27:0]           req_line;
  logic [INDEX_BITS-1:0] idx;
  logic [TAG_BITS-1:0]   req_tag;
  logic [LINES-1:0]      valid_q;
  logic [TAG_BITS-1:0]   tag_mem  [LINES];
  logic [127:0]          data_mem [LINES];
  logic [31:0]           line_buf [4];
  logic [1:0]            beat;
  logic                  match, hit, beat_acc, last_beat;
  logic                  addr_offset_unused;

  assign idx                = req_line[INDEX_BITS-1:0];
  assign req_tag            = req_line[27:INDEX_BITS];
  assign match              = (addr[31:4] == req_line);
  assign hit                = valid_q[idx] && (tag_mem[idx] == req_tag);
  assign beat_acc           = (state == REFILL) && mem_data_valid;
  assign last_beat          = beat_acc && (beat == 2'd3);
  assign addr_offset_unused = ^addr[3:0];

  // Gated live against the current address so a redirect during RESP kills the pulse
  assign dout_valid = (state == RESP) && rd_en && match;

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:   if (rd_en) state_nxt = LOOKUP;
      LOOKUP: begin
        if (!match)   state_nxt = IDLE;
        else if (hit) state_nxt = RESP;
        else          state_nxt = REFILL;
      end
      REFILL: if (last_beat) state_nxt = match ? RESP : IDLE;
      RESP:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state     <= IDLE;
      req_line  <= '0;
      dout      <= '0;
      mem_rd_en <= 1'b0;
      mem_addr  <= '0;
      beat      <= '0;
      valid_q   <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && rd_en) req_line <= addr[31:4];
      if (state == LOOKUP && match && hit) dout <= data_mem[idx];
      if (state == LOOKUP && match && !hit) begin
        mem_rd_en <= 1'b1;
        mem_addr  <= {req_line, 4'h0};
        beat      <= '0;
      end
      if (beat_acc) begin
        beat     <= beat + 2'd1;
        mem_addr <= mem_addr + 32'd4;
      end
      // A refill always installs its line, even if the request went stale meanwhile
      if (last_beat) begin
        mem_rd_en    <= 1'b0;
        valid_q[idx] <= 1'b1;
        dout         <= {mem_data, line_buf[2], line_buf[1], line_buf[0]};
      end
    end
  end

  always_ff @(posedge clock) begin
    if (beat_acc) line_buf[beat] <= mem_data;
    if (last_beat) begin
      data_mem[idx] <= {mem_data, line_buf[2], line_buf[1], line_buf[0]};
      tag_mem[idx]  <= req_tag;
    end
  end

endmodule

// File: tb/tb_icache_fetch.sv
// Scoreboard bench for icache_fetch: directed scenarios plus random requests
// against a line-residency model and a beat-level memory responder.
module tb_icache_fetch;
  localparam int INDEX_BITS = 6;

  logic         clock = 1'b0;
  logic         nreset = 1'b0;
  logic         rd_en = 1'b0;
  logic [31:0]  addr = '0;
  logic [127:0] dout;
  logic         dout_valid;
  logic         mem_rd_en;
  logic [31:0]  mem_addr;
  logic [31:0]  mem_data = '0;
  logic         mem_data_valid = 1'b0;

  icache_fetch #(.INDEX_BITS(INDEX_BITS)) dut (
    .clock(clock), .nreset(nreset), .rd_en(rd_en), .addr(addr),
    .dout(dout), .dout_valid(dout_valid), .mem_rd_en(mem_rd_en),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_data_valid(mem_data_valid)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  logic [127:0] resp_q[$];
  logic [31:0]  refill_q[$];
  logic [31:0]  resident [int];
  logic [31:0]  mem_ovr [logic [31:0]];
  int fixed_gap = -1;
  int beats_acc = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (mem_ovr.exists(a)) return mem_ovr[a];
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [127:0] line_of(input logic [31:0] b);
    return {mem_word(b + 32'd12), mem_word(b + 32'd8), mem_word(b + 32'd4), mem_word(b)};
  endfunction

  // Which line lives at each index; a miss queues a refill and installs the line
  function automatic bit expect_req(input logic [31:0] a, input bit want_resp);
    logic [31:0] line;
    int ix;
    bit h;
    line = a & 32'hFFFF_FFF0;
    ix = int'((a >> 4) & ((32'd1 << INDEX_BITS) - 1));
    h = resident.exists(ix) && (resident[ix] == line);
    if (!h) begin
      refill_q.push_back(line);
      resident[ix] = line;
    end
    if (want_resp) resp_q.push_back(line_of(line));
    return h;
  endfunction

  // Response monitor
  always @(negedge clock) begin
    if (dout_valid) begin
      if (resp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_dout_valid: got dout %h with nothing expected", dout);
      end else begin
        chk("dout_line", dout, resp_q.pop_front());
      end
    end
  end

  // Memory responder: checks beat addresses, supplies data, injects stray valids when idle
  bit          active = 1'b0;
  int          beat_n = 0;
  int          gap = 0;
  logic [31:0] exp_line = '0;

  function automatic int pick_gap();
    return (fixed_gap >= 0) ? fixed_gap : int'($urandom_range(3));
  endfunction

  always @(negedge clock) begin
    if (!nreset) begin
      active = 1'b0;
      mem_data_valid = 1'b0;
    end else begin
      if (active && mem_data_valid) begin
        beat_n++;
        beats_acc++;
      end
      if (active && beat_n == 4) begin
        active = 1'b0;
        chk("mem_rd_en_fall", mem_rd_en, 1'b0);
      end
      if (!active && mem_rd_en) begin
        active = 1'b1;
        beat_n = 0;
        gap = pick_gap();
        if (refill_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_refill: got mem_addr %h with no refill expected", mem_addr);
          exp_line = mem_addr;
        end else begin
          exp_line = refill_q.pop_front();
        end
      end
      mem_data_valid = 1'b0;
      mem_data = $urandom;
      if (active) begin
        if (gap > 0) gap--;
        else begin
          chk("mem_addr_beat", mem_addr, exp_line + 32'(4 * beat_n));
          mem_data = mem_word(exp_line + 32'(4 * beat_n));
          mem_data_valid = 1'b1;
          gap = pick_gap();
        end
      end else if ($urandom_range(3) == 0) begin
        mem_data_valid = 1'b1;
      end
    end
  end

  task automatic wait_resp(output int lat, output bit memflag, output bit got);
    lat = 0;
    memflag = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 300 && !got; i++) begin
      @(posedge clock);
      lat++;
      @(negedge clock);
      if (mem_rd_en) memflag = 1'b1;
      if (dout_valid) got = 1'b1;
    end
    @(posedge clock);
    #1;
    rd_en = 1'b0;
    addr = $urandom;
    chk("resp_seen", got, 1'b1);
  endtask

  task automatic do_req(input logic [31:0] a);
    bit h, memflag, got;
    int lat;
    h = expect_req(a, 1'b1);
    @(posedge clock);
    #1;
    rd_en = 1'b1;
    addr = a;
    wait_resp(lat, memflag, got);
    if (h) begin
      chk("hit_latency", lat, 2);
      chk("hit_no_mem_rd", memflag, 1'b0);
    end
  endtask

  task automatic stale_redirect();
    bit seen, memflag, got;
    int lat;
    void'(expect_req(32'h0000_0080, 1'b0));
    void'(expect_req(32'h0000_1000, 1'b1));
    @(posedge clock);
    #1;
    rd_en = 1'b1;
    addr = 32'h0000_0080;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clock);
      seen = mem_rd_en;
    end
    chk("stale_refill_start", seen, 1'b1);
    addr = 32'h0000_1000;
    wait_resp(lat, memflag, got);
    do_req(32'h0000_0080);
  endtask

  task automatic resp_redirect();
    bit memflag, got;
    int lat;
    void'(expect_req(32'h0000_0040, 1'b0));
    void'(expect_req(32'h0000_2000, 1'b1));
    @(posedge clock);
    #1;
    rd_en = 1'b1;
    addr = 32'h0000_0040;
    @(posedge clock);
    @(posedge clock);
    #1;
    addr = 32'h0000_2000;
    @(negedge clock);
    chk("resp_redirect_kill", dout_valid, 1'b0);
    wait_resp(lat, memflag, got);
  endtask

  task automatic reset_midrefill();
    bit memflag, got;
    int lat, base;
    void'(expect_req(32'h0000_0300, 1'b1));
    fixed_gap = 2;
    base = beats_acc;
    @(posedge clock);
    #1;
    rd_en = 1'b1;
    addr = 32'h0000_0300;
    for (int i = 0; i < 200 && beats_acc < base + 2; i++) @(negedge clock);
    chk("reset_two_beats", beats_acc - base, 2);
    #1;
    nreset = 1'b0;
    rd_en = 1'b0;
    #1;
    chk("reset_mem_rd_en", mem_rd_en, 1'b0);
    chk("reset_dout_valid", dout_valid, 1'b0);
    resp_q.delete();
    refill_q.delete();
    resident.delete();
    repeat (2) @(posedge clock);
    @(negedge clock);
    #1;
    nreset = 1'b1;
    fixed_gap = -1;
    lat = 0;
    memflag = 1'b0;
    got = 1'b0;
    do_req(32'h0000_0300);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] ra;
    mem_ovr[32'h40] = 32'h1111_1111;
    mem_ovr[32'h44] = 32'h2222_2222;
    mem_ovr[32'h48] = 32'h3333_3333;
    mem_ovr[32'h4C] = 32'h4444_4444;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_dout", dout, '0);
    chk("rst_dout_valid", dout_valid, 1'b0);
    chk("rst_mem_rd_en", mem_rd_en, 1'b0);
    chk("rst_mem_addr", mem_addr, '0);
    #1;
    nreset = 1'b1;

    fixed_gap = 2;
    do_req(32'h0000_0040);
    do_req(32'h0000_004C);
    fixed_gap = -1;
    do_req(32'h0000_0440);
    do_req(32'h0000_0040);
    stale_redirect();
    resp_redirect();
    reset_midrefill();

    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(3) == 0) repeat ($urandom_range(3)) @(posedge clock);
      ra = (32'($urandom_range(3)) << 10) | (32'($urandom_range(7)) << 4) | 32'($urandom_range(15));
      do_req(ra);
    end

    repeat (10) @(posedge clock);
    @(negedge clock);
    chk("resp_queue_drained", resp_q.size(), 0);
    chk("refill_queue_drained", refill_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
